test_seq_ctrl: RTL

- Host-facing sequencer upstream of the DUT interface. Accepts test commands from the host and writes mux-setup words into the DI FIFO.
- Streams stimulus vectors from the on-chip vector memory into the STIM FIFO, then counts returned results until all have arrived or a timeout expires.
- Runs on the gated DUT clock, so it stalls together with the DUT path when the result FIFO is full.

---
 rtl/test_seq_pkg.sv | 27 ++
 rtl/test_seq_stream.sv | 78 +++++++
 rtl/test_seq_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/test_seq_pkg.sv
// Shared opcodes, DI command header, FSM state encoding and default widths
// for the test sequencer.
package test_seq_pkg;

  localparam int DEF_STF_WIDTH      = 24;
  localparam int DEF_REQ_WIDTH      = 3;
  localparam int DEF_CMD_WIDTH      = 5;
  localparam int DEF_ADDR_WIDTH     = 12;
  localparam int DEF_LEN_WIDTH      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  localparam logic [2:0] OP_NOP         = 3'b000;
  localparam logic [2:0] OP_SETUP_MUXES = 3'b001;
  localparam logic [2:0] OP_RUN         = 3'b010;

  // Occupies the REQ+CMD header bits above the mux configuration word
  localparam logic [7:0] DICMD_SETUP_MUXES = 8'b00000001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/test_seq_stream.sv
// Streams vectors from the vector memory into the STIM FIFO, with a
// one-entry skid buffer catching the word in flight when the FIFO fills.
module test_seq_stream
  import test_seq_pkg::*;
#(
  parameter int STF_WIDTH  = DEF_STF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clock_gated,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  vmem_rden,
  output logic [ADDR_WIDTH-1:0] vmem_addr,
  input  logic [STF_WIDTH-1:0]  vmem_q,
  input  logic                  fifo_full,
  output logic                  fifo_wrreq,
  output logic [STF_WIDTH-1:0]  fifo_wrdata,
  output logic                  finished
);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  written_q;
  logic                  data_valid_q;
  logic                  skid_valid_q;
  logic [STF_WIDTH-1:0]  skid_q;

  // A read is only issued when its data is sure to find room: FIFO not full
  // and skid empty, so skid and returning data can never both be pending.
  always_comb begin
    vmem_rden   = (issued_q < len_q) && !fifo_full && !skid_valid_q;
    vmem_addr   = base_q + issued_q[ADDR_WIDTH-1:0];
    fifo_wrreq  = (skid_valid_q || data_valid_q) && !fifo_full;
    fifo_wrdata = '0;
    if (fifo_wrreq) begin
      fifo_wrdata = skid_valid_q ? skid_q : vmem_q;
    end
    finished    = (written_q == len_q);
  end

  always_ff @(posedge clock_gated or negedge reset_n) begin
    if (!reset_n) begin
      base_q       <= '0;
      len_q        <= '0;
      issued_q     <= '0;
      written_q    <= '0;
      data_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else if (start) begin
      base_q       <= base;
      len_q        <= len;
      issued_q     <= '0;
      written_q    <= '0;
      data_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      if (vmem_rden) begin
        issued_q <= issued_q + LEN_WIDTH'(1);
      end
      if (fifo_wrreq) begin
        written_q <= written_q + LEN_WIDTH'(1);
      end
      data_valid_q <= vmem_rden;
      if (data_valid_q && fifo_full) begin
        skid_valid_q <= 1'b1;
        skid_q       <= vmem_q;
      end else if (skid_valid_q && !fifo_full) begin
        skid_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/test_seq_ctrl.sv
// Host command sequencer: SETUP writes a mux word to the DI FIFO, RUN streams
// vectors and counts results. Define TEST_SEQ_TIMEOUT_EN for the drain timeout.
module test_seq_ctrl
  import test_seq_pkg::*;
#(
  parameter int STF_WIDTH  = DEF_STF_WIDTH,
  parameter int REQ_WIDTH  = DEF_REQ_WIDTH,
  parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
`ifdef TEST_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                                   clock_gated,
  input  logic                                   reset_n,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [2:0]                             cmd_op,
  input  logic [STF_WIDTH-1:0]                   cmd_arg,
  input  logic [LEN_WIDTH-1:0]                   cmd_len,
  output logic                                   vmem_rden,
  output logic [ADDR_WIDTH-1:0]                  vmem_addr,
  input  logic [STF_WIDTH-1:0]                   vmem_q,
  output logic [REQ_WIDTH+CMD_WIDTH+STF_WIDTH-1:0] dififo_wrdata,
  output logic                                   dififo_wrreq,
  input  logic                                   dififo_wrfull,
  output logic [STF_WIDTH-1:0]                   sfifo_wrdata,
  output logic                                   sfifo_wrreq,
  input  logic                                   sfifo_wrfull,
  input  logic                                   res_strobe,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   timeout,
  output logic                                   overrun,
  output logic                                   bad_op,
  output logic [LEN_WIDTH-1:0]                   res_count
);

  localparam int HDR_WIDTH = REQ_WIDTH + CMD_WIDTH;

  state_t               state_q, state_d;
  logic [STF_WIDTH-1:0] arg_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] res_count_q;
  logic                 timeout_q, overrun_q, bad_op_q;
  logic                 accept, counting, stream_start, stream_finished, tmo_expire;

  assign accept       = cmd_valid && (state_q == ST_IDLE);
  assign counting     = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign stream_start = accept && (cmd_op == OP_RUN);

  test_seq_stream #(
    .STF_WIDTH (STF_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_stream (
    .clock_gated(clock_gated),
    .reset_n    (reset_n),
    .start      (stream_start),
    .base       (cmd_arg[ADDR_WIDTH-1:0]),
    .len        (cmd_len),
    .vmem_rden  (vmem_rden),
    .vmem_addr  (vmem_addr),
    .vmem_q     (vmem_q),
    .fifo_full  (sfifo_wrfull),
    .fifo_wrreq (sfifo_wrreq),
    .fifo_wrdata(sfifo_wrdata),
    .finished   (stream_finished)
  );

`ifdef TEST_SEQ_TIMEOUT_EN
  localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_WIDTH-1:0] tmo_cnt_q;

  // Idle-cycle counter between results; any strobe restarts the window.
  always_ff @(posedge clock_gated or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_DRAIN) && !res_strobe) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_WIDTH'(1);
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign tmo_expire = (state_q == ST_DRAIN) && !res_strobe &&
                      (res_count_q != len_q) &&
                      (tmo_cnt_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_SETUP_MUXES: state_d = ST_SETUP;
            OP_RUN:         state_d = ST_STREAM;
            default:        state_d = ST_DONE;
          endcase
        end
      end
      ST_SETUP:  if (!dififo_wrfull) state_d = ST_DONE;
      ST_STREAM: if (stream_finished) state_d = ST_DRAIN;
      ST_DRAIN:  if ((res_count_q == len_q) || tmo_expire) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state_q == ST_IDLE);
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    dififo_wrreq  = (state_q == ST_SETUP) && !dififo_wrfull;
    dififo_wrdata = '0;
    if (dififo_wrreq) begin
      dififo_wrdata = {HDR_WIDTH'(DICMD_SETUP_MUXES), arg_q};
    end
  end

  // Results are counted through STREAM and DRAIN; one past len flags overrun.
  always_ff @(posedge clock_gated or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      arg_q       <= '0;
      len_q       <= '0;
      res_count_q <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      bad_op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        arg_q       <= cmd_arg;
        len_q       <= cmd_len;
        res_count_q <= '0;
        timeout_q   <= 1'b0;
        overrun_q   <= 1'b0;
        if ((cmd_op != OP_NOP) && (cmd_op != OP_SETUP_MUXES) && (cmd_op != OP_RUN)) begin
          bad_op_q <= 1'b1;
        end
      end else begin
        if (counting && res_strobe) begin
          if (res_count_q == len_q) begin
            overrun_q <= 1'b1;
          end else if (res_count_q != '1) begin
            res_count_q <= res_count_q + LEN_WIDTH'(1);
          end
        end
        if (tmo_expire) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign timeout   = timeout_q;
  assign overrun   = overrun_q;
  assign bad_op    = bad_op_q;
  assign res_count = res_count_q;

endmodule
